uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) feeding a show-ahead receive FIFO.
// The serial line is synchronized, start edges are qualified at mid-bit,
// each data bit is sampled once per bit period at its centre, and good
// bytes are queued for the consumer. Framing errors and overflows are
// reported as single-cycle pulses.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic                          i_rx,
  output logic [7:0]                    o_rd_data,
  output logic                          o_rd_valid,
  input  logic                          i_rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_frame_err,
  output logic                          o_overflow
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);

  // Counter reload values: the counter runs down to zero and the action
  // happens on the edge where it is already zero, so N-cycle waits load N-1.
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

  rx_state_t        state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;

  logic             rx_meta;
  logic             rxs;
  logic             rxs_prev;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic             fifo_full;
  logic             pop;
  logic             stop_sample;
  logic             push;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  // All three idle high so reset never looks like a start edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= i_rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  assign fifo_full   = (count == (AW+1)'(FIFO_DEPTH));
  assign o_rd_valid  = (count != '0);
  assign pop         = o_rd_valid && i_rd_ready;
  assign stop_sample = (state == ST_STOP) && (bit_cnt == '0);
  // A good byte is accepted when there is room, or when the head leaves in
  // the same cycle and frees the slot.
  assign push        = stop_sample && rxs && (!fifo_full || pop);

  // Receive FSM: start qualification, data shifting, stop check and the
  // registered error pulses.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      rx_shift    <= '0;
      o_frame_err <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overflow  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Only a 1->0 transition starts a frame; a line stuck low does not.
          if (rxs_prev && !rxs) begin
            state   <= ST_START;
            bit_cnt <= HALF_LOAD;
          end
        end
        ST_START: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end else if (!rxs) begin
            state   <= ST_DATA;
            bit_cnt <= FULL_LOAD;
            bit_idx <= '0;
          end else begin
            state   <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end else begin
            rx_shift[bit_idx] <= rxs;
            bit_cnt           <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end else begin
            state <= ST_IDLE;
            if (!rxs) begin
              o_frame_err <= 1'b1;
            end else if (!push) begin
              o_overflow  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; entries are only ever read after
  // being written, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_shift;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Head byte is forced to zero when empty so the output is defined in reset.
  assign o_rd_data    = o_rd_valid ? mem[rd_ptr] : 8'h00;
  assign o_fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// bytes, compared against a queue-based model of the receive path.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_rd_ready = 1'b0;
  logic [7:0] o_rd_data;
  logic       o_rd_valid;
  logic [3:0] o_fifo_count;
  logic       o_frame_err;
  logic       o_overflow;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_rx        (i_rx),
    .o_rd_data   (o_rd_data),
    .o_rd_valid  (o_rd_valid),
    .i_rd_ready  (i_rd_ready),
    .o_fifo_count(o_fifo_count),
    .o_frame_err (o_frame_err),
    .o_overflow  (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Pulse counters, written only by the monitor.
  int fe_cnt = 0;
  int ov_cnt = 0;

  // Model state.
  byte unsigned q[$];
  int  exp_fe = 0;
  int  exp_ov = 0;
  bit  pop_at_stop = 1'b0;

  always @(negedge i_clk) begin
    if (i_rstn) begin
      if (o_frame_err) fe_cnt++;
      if (o_overflow)  ov_cnt++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Hold the line at one level for one bit period; ends 1 ns after an edge.
  task automatic drive_bit(input logic v);
    i_rx = v;
    repeat (CPB) @(posedge i_clk);
    #1;
  endtask

  // Send one frame and update the model with the expected outcome.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge i_clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    i_rx = stop;
    repeat (10) @(posedge i_clk); #1;
    if (pop_at_stop) i_rd_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rd_ready = 1'b0;
    repeat (5) @(posedge i_clk); #1;
    i_rx = 1'b1;
    repeat (4) @(posedge i_clk); #1;
    if (pop_at_stop && q.size() > 0) void'(q.pop_front());
    if (!stop) exp_fe++;
    else if (q.size() < DEPTH) q.push_back(d);
    else exp_ov++;
  endtask

  // Check the head against the model and pop it with a single-cycle ready.
  task automatic pop_check(input string tag);
    @(negedge i_clk);
    check({tag, "_valid"}, 32'(o_rd_valid), 32'd1);
    check({tag, "_data"},  32'(o_rd_data),  32'(q[0]));
    @(posedge i_clk); #1;
    i_rd_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rd_ready = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic check_status(input string tag);
    @(negedge i_clk);
    check({tag, "_count"}, 32'(o_fifo_count), 32'(q.size()));
    check({tag, "_valid"}, 32'(o_rd_valid),   32'(q.size() != 0));
    check({tag, "_fe"},    32'(fe_cnt),       32'(exp_fe));
    check({tag, "_ov"},    32'(ov_cnt),       32'(exp_ov));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(o_rd_valid),   32'd0);
    check({tag, "_count"}, 32'(o_fifo_count), 32'd0);
    check({tag, "_fe"},    32'(o_frame_err),  32'd0);
    check({tag, "_ov"},    32'(o_overflow),   32'd0);
    check({tag, "_data"},  32'(o_rd_data),    32'd0);
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] rst_byte;

    // Power-on reset.
    #3;
    check_reset_outputs("por");
    repeat (3) @(posedge i_clk); #1;
    i_rstn = 1'b1;
    repeat (5) @(posedge i_clk); #1;
    check_status("idle");

    // Single byte, no reads.
    send_frame(8'hA5, 1'b1);
    check_status("a5");
    @(negedge i_clk);
    check("a5_data", 32'(o_rd_data), 32'h0000_00A5);
    pop_check("a5_pop");
    check_status("a5_after");

    // Short low glitch: no frame, then a normal byte still decodes.
    @(posedge i_clk); #1;
    i_rx = 1'b0;
    repeat (4) @(posedge i_clk); #1;
    i_rx = 1'b1;
    repeat (30) @(posedge i_clk); #1;
    check_status("glitch");
    rb = 8'($urandom);
    send_frame(rb, 1'b1);
    check_status("post_glitch");
    pop_check("post_glitch_pop");

    // Framing error.
    send_frame(8'h3C, 1'b0);
    check_status("ferr");

    // Fill past capacity.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    check_status("fill9");
    check("fill9_count8", 32'(o_fifo_count), 32'd8);
    for (int i = 0; i < 8; i++) pop_check("drain");
    check_status("drained");

    // Full FIFO with a pop coinciding with the stop-bit sample.
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1);
    check_status("full");
    pop_at_stop = 1'b1;
    send_frame(8'hE7, 1'b1);
    pop_at_stop = 1'b0;
    check_status("full_pushpop");
    while (q.size() > 0) pop_check("full_drain");

    // Ready asserted while empty has no effect.
    @(posedge i_clk); #1;
    i_rd_ready = 1'b1;
    repeat (5) @(posedge i_clk); #1;
    i_rd_ready = 1'b0;
    check_status("empty_pop");

    // Randomized traffic with random reads, including random bad stops.
    for (int n = 0; n < 12; n++) begin
      int npop;
      send_frame(8'($urandom), ($urandom_range(0, 5) != 0));
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop; j++) if (q.size() > 0) pop_check("rnd_pop");
      check_status("rnd");
    end
    while (q.size() > 0) pop_check("rnd_drain");

    // Reset in the middle of data bit 3 with bytes held.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rst_byte = 8'h96;
    @(posedge i_clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(rst_byte[i]);
    i_rx = rst_byte[3];
    repeat (8) @(posedge i_clk); #1;
    i_rstn = 1'b0;
    #2;
    check_reset_outputs("midrst");
    q.delete();
    i_rx = 1'b1;
    repeat (5) @(posedge i_clk); #1;
    i_rstn = 1'b1;
    repeat (20) @(posedge i_clk); #1;
    check_status("after_rst");
    send_frame(8'h5A, 1'b1);
    check_status("rx5a");
    pop_check("rx5a_pop");
    check_status("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
